vz_upload: RTL and testbench



---
 rtl/vz_pkg.sv | 38 +++
 rtl/vz_header_rom.sv | 41 ++++
 rtl/vz_upload.sv | 214 +++++++++++++++++++++
 tb/tb_vz_upload.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vz_pkg.sv
// -----------------------------------------------------------------------------
// vz_pkg
// Shared definitions for the VZ upload path: the FSM state encoding, the fixed
// header length, the header text constants and the default Laser310 memory map
// locations used when no override is given.
// Ports: none (package).
// -----------------------------------------------------------------------------
package vz_pkg;

   // Upload sequencer states, in the order a normal session walks through them
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      PTR_LO = 3'd1,
      PTR_HI = 3'd2,
      CALC   = 3'd3,
      READY  = 3'd4,
      FETCH  = 3'd5,
      DATA   = 3'd6
   } vzState_e;

   // Size of the synthesised VZ header that precedes the program bytes
   localparam int VZ_HDR_LEN = 24;

   // Largest program length that still keeps header + program within 16 bits
   localparam logic [15:0] VZ_MAX_PROG_LEN = 16'hFFE7;

   // "VZF0" with byte 0 in the least significant position
   localparam logic [31:0] VZ_MAGIC = 32'h30_46_5A_56;

   // "LASER310" with byte 0 in the least significant position
   localparam logic [63:0] VZ_NAME = 64'h30_31_33_52_45_53_41_4C;

   // Laser310 BASIC program area and the system variable holding its end
   localparam logic [15:0] VZ_DEFAULT_START_ADDR = 16'h7AE9;
   localparam logic [15:0] VZ_DEFAULT_END_PTR    = 16'h78F9;
   localparam logic [7:0]  VZ_DEFAULT_FILE_TYPE  = 8'hF0;

endpackage

// File: rtl/vz_header_rom.sv
// -----------------------------------------------------------------------------
// vz_header_rom
// Combinational lookup of the 24-byte VZ file header.
//   offset_i [4:0]  header byte offset (0..23; larger offsets read as 00)
//   data_o   [7:0]  header byte at that offset
// Layout: "VZF0", "LASER310" padded with zeros to 17 bytes, file type byte,
// then the little-endian load address.
// -----------------------------------------------------------------------------
module vz_header_rom
   import vz_pkg::*;
#(
   parameter logic [7:0]  FILE_TYPE  = VZ_DEFAULT_FILE_TYPE,
   parameter logic [15:0] START_ADDR = VZ_DEFAULT_START_ADDR
) (
   input  logic [4:0] offset_i,
   output logic [7:0] data_o
);

   logic [2:0] nameIdx;

   // The filename starts at offset 4; a 3-bit subtraction maps offsets 4..11
   // onto name characters 0..7 without needing the upper offset bits.
   assign nameIdx = offset_i[2:0] - 3'd4;

   // Select magic, filename, padding, type byte or load address by offset range
   always_comb begin
      data_o = 8'h00;
      if (offset_i < 5'd4) begin
         data_o = VZ_MAGIC[{offset_i[1:0], 3'b000} +: 8];
      end else if (offset_i < 5'd12) begin
         data_o = VZ_NAME[{nameIdx, 3'b000} +: 8];
      end else if (offset_i == 5'd21) begin
         data_o = FILE_TYPE;
      end else if (offset_i == 5'd22) begin
         data_o = START_ADDR[7:0];
      end else if (offset_i == 5'd23) begin
         data_o = START_ADDR[15:8];
      end
   end

endmodule

// File: rtl/vz_upload.sv
// -----------------------------------------------------------------------------
// vz_upload
// Streams the Laser310 BASIC program out of main RAM as a .VZ file during an
// hps_io upload session. The header is synthesised, the file size comes from
// the BASIC end pointer, and program bytes are fetched on demand while the
// host is held off with ioctl_wait.
//   clk_sys       system clock
//   reset         synchronous active-high reset
//   ioctl_upload  upload session active (level)
//   ioctl_rd      one-cycle read strobe for the byte at ioctl_addr
//   ioctl_addr    file byte offset
//   ioctl_din     byte returned to the host (holds between reads)
//   ioctl_wait    host must stall while high
//   ram_addr      RAM read address
//   ram_rd        RAM read strobe, data valid one cycle later on ram_dout
//   ram_dout      RAM read data
//   upload_size   header + program length in bytes
//   size_valid    upload_size is meaningful
//   busy          sequencer is not idle
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module vz_upload
   import vz_pkg::*;
#(
   parameter logic [15:0] START_ADDR = VZ_DEFAULT_START_ADDR,
   parameter logic [15:0] END_PTR    = VZ_DEFAULT_END_PTR,
   parameter logic [7:0]  FILE_TYPE  = VZ_DEFAULT_FILE_TYPE
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        ioctl_upload,
   input  logic        ioctl_rd,
   input  logic [15:0] ioctl_addr,
   output logic [7:0]  ioctl_din,
   output logic        ioctl_wait,
   output logic [15:0] ram_addr,
   output logic        ram_rd,
   input  logic [7:0]  ram_dout,
   output logic [15:0] upload_size,
   output logic        size_valid,
   output logic        busy
);

   localparam logic [15:0] HDR_LEN = 16'(VZ_HDR_LEN);

   vzState_e    state_q, state_d;
   logic        uploadPrev_q;
   logic [7:0]  endLo_q;

   logic [7:0]  din_q, din_d;
   logic        wait_q, wait_d;
   logic [15:0] ramAddr_q, ramAddr_d;
   logic        ramRd_q, ramRd_d;
   logic [15:0] size_q, size_d;
   logic        sizeValid_q, sizeValid_d;
   logic        busy_q, busy_d;

   logic        uploadRise;
   logic        isHeader;
   logic        isProgram;
   logic [15:0] endPtr;
   logic [15:0] progLen;
   logic [7:0]  hdrByte;

   vz_header_rom #(
      .FILE_TYPE  (FILE_TYPE),
      .START_ADDR (START_ADDR)
   ) headerRom (
      .offset_i (ioctl_addr[4:0]),
      .data_o   (hdrByte)
   );

   assign uploadRise = ioctl_upload & ~uploadPrev_q;
   assign isHeader   = (ioctl_addr < HDR_LEN);
   assign isProgram  = !isHeader && (ioctl_addr < size_q);

   // The high pointer byte is on ram_dout during CALC, so the length is formed
   // from it directly and committed to size_q on the way into READY.
   assign endPtr = {ram_dout, endLo_q};

   // Program length: empty when the end pointer does not lie past the start,
   // and clamped so that adding the header cannot wrap 16 bits.
   always_comb begin
      progLen = 16'h0000;
      if (endPtr > START_ADDR) begin
         progLen = endPtr - START_ADDR;
         if (progLen > VZ_MAX_PROG_LEN) begin
            progLen = VZ_MAX_PROG_LEN;
         end
      end
   end

   // State register plus the delayed upload level used for edge detection
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q      <= IDLE;
         uploadPrev_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         uploadPrev_q <= ioctl_upload;
      end
   end

   // Next-state logic; losing the upload level abandons whatever is in flight
   always_comb begin
      state_d = state_q;
      if (!ioctl_upload) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (uploadRise) state_d = PTR_LO;
            PTR_LO:  state_d = PTR_HI;
            PTR_HI:  state_d = CALC;
            CALC:    state_d = READY;
            READY:   if (ioctl_rd && isProgram) state_d = FETCH;
            FETCH:   state_d = DATA;
            DATA:    state_d = READY;
            default: state_d = IDLE;
         endcase
      end
   end

   // Output next values are decoded from the upcoming state so that every
   // output can be a plain register and an aborted read never pulses ram_rd.
   always_comb begin
      din_d       = din_q;
      wait_d      = 1'b0;
      ramAddr_d   = 16'h0000;
      ramRd_d     = 1'b0;
      size_d      = size_q;
      sizeValid_d = sizeValid_q;
      busy_d      = (state_d != IDLE);
      case (state_d)
         IDLE: begin
            din_d       = 8'h00;
            size_d      = 16'h0000;
            sizeValid_d = 1'b0;
         end
         PTR_LO: begin
            wait_d    = 1'b1;
            ramRd_d   = 1'b1;
            ramAddr_d = END_PTR;
         end
         PTR_HI: begin
            wait_d    = 1'b1;
            ramRd_d   = 1'b1;
            ramAddr_d = END_PTR + 16'd1;
         end
         CALC: begin
            wait_d = 1'b1;
         end
         READY: begin
            if (state_q == CALC) begin
               size_d      = HDR_LEN + progLen;
               sizeValid_d = 1'b1;
            end else if (state_q == DATA) begin
               din_d = ram_dout;
            end else if (ioctl_rd) begin
               din_d = isHeader ? hdrByte : 8'h00;
            end
         end
         FETCH: begin
            wait_d    = 1'b1;
            ramRd_d   = 1'b1;
            ramAddr_d = START_ADDR + ioctl_addr - HDR_LEN;
         end
         DATA: begin
            wait_d = 1'b1;
         end
         default: begin
            din_d = din_q;
         end
      endcase
   end

   // Output registers
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         din_q       <= 8'h00;
         wait_q      <= 1'b0;
         ramAddr_q   <= 16'h0000;
         ramRd_q     <= 1'b0;
         size_q      <= 16'h0000;
         sizeValid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         din_q       <= din_d;
         wait_q      <= wait_d;
         ramAddr_q   <= ramAddr_d;
         ramRd_q     <= ramRd_d;
         size_q      <= size_d;
         sizeValid_q <= sizeValid_d;
         busy_q      <= busy_d;
      end
   end

   // Low end-pointer byte arrives on ram_dout while in PTR_HI
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         endLo_q <= 8'h00;
      end else if (state_q == PTR_HI) begin
         endLo_q <= ram_dout;
      end
   end

   assign ioctl_din   = din_q;
   assign ioctl_wait  = wait_q;
   assign ram_addr    = ramAddr_q;
   assign ram_rd      = ramRd_q;
   assign upload_size = size_q;
   assign size_valid  = sizeValid_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_vz_upload.sv
// -----------------------------------------------------------------------------
// tb_vz_upload
// Self-checking bench for vz_upload with a behavioural RAM (one-cycle read
// latency) and a queue of expected bytes for each host read.
// -----------------------------------------------------------------------------
module tb_vz_upload;

   logic        clk_sys = 1'b0;
   logic        reset;
   logic        ioctl_upload;
   logic        ioctl_rd;
   logic [15:0] ioctl_addr;
   logic [7:0]  ioctl_din;
   logic        ioctl_wait;
   logic [15:0] ram_addr;
   logic        ram_rd;
   logic [7:0]  ram_dout = 8'h00;
   logic [15:0] upload_size;
   logic        size_valid;
   logic        busy;

   logic [7:0]  mem [0:65535];
   logic [7:0]  expQ [$];

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [15:0] addr;
      logic [7:0]  din;
      bit          prog;
   } vec_t;

   vec_t vecs [27];

   vz_upload dut (
      .clk_sys      (clk_sys),
      .reset        (reset),
      .ioctl_upload (ioctl_upload),
      .ioctl_rd     (ioctl_rd),
      .ioctl_addr   (ioctl_addr),
      .ioctl_din    (ioctl_din),
      .ioctl_wait   (ioctl_wait),
      .ram_addr     (ram_addr),
      .ram_rd       (ram_rd),
      .ram_dout     (ram_dout),
      .upload_size  (upload_size),
      .size_valid   (size_valid),
      .busy         (busy)
   );

   // 10 ns clock
   always #5 clk_sys = ~clk_sys;

   // RAM model: read data appears the cycle after the strobe
   always @(posedge clk_sys) begin
      if (ram_rd) ram_dout <= mem[ram_addr];
   end

   // Guard against a stuck run
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Advance to just after the next rising edge
   task automatic tick;
      @(posedge clk_sys);
      #1;
   endtask

   // Single comparison, counted
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Every output must be zero in IDLE / after reset
   task automatic checkIdle(input string tag);
      checkOutput({tag, ".din"},       32'(ioctl_din),   32'h0);
      checkOutput({tag, ".wait"},      32'(ioctl_wait),  32'h0);
      checkOutput({tag, ".ramAddr"},   32'(ram_addr),    32'h0);
      checkOutput({tag, ".ramRd"},     32'(ram_rd),      32'h0);
      checkOutput({tag, ".size"},      32'(upload_size), 32'h0);
      checkOutput({tag, ".sizeValid"}, 32'(size_valid),  32'h0);
      checkOutput({tag, ".busy"},      32'(busy),        32'h0);
   endtask

   // Raise the upload level and follow the pointer read sequence into READY
   task automatic raiseUpload(input logic [15:0] expSize);
      ioctl_upload = 1'b1;
      tick;
      checkOutput("ptrLo.wait",    32'(ioctl_wait), 32'h1);
      checkOutput("ptrLo.ramRd",   32'(ram_rd),     32'h1);
      checkOutput("ptrLo.ramAddr", 32'(ram_addr),   32'h78F9);
      checkOutput("ptrLo.busy",    32'(busy),       32'h1);
      tick;
      checkOutput("ptrHi.ramAddr", 32'(ram_addr),   32'h78FA);
      tick;
      checkOutput("calc.wait",     32'(ioctl_wait), 32'h1);
      checkOutput("calc.ramRd",    32'(ram_rd),     32'h0);
      tick;
      checkOutput("ready.wait",      32'(ioctl_wait),  32'h0);
      checkOutput("ready.sizeValid", 32'(size_valid),  32'h1);
      checkOutput("ready.size",      32'(upload_size), 32'(expSize));
   endtask

   // One host read: push the expected byte, strobe, follow the handshake and
   // pop/compare once the DUT presents the byte
   task automatic applyStimulus(input logic [15:0] a, input logic [7:0] exp, input bit prog);
      logic [15:0] expAddr;
      int n;
      expAddr = 16'h7AE9 + a - 16'd24;
      expQ.push_back(exp);
      ioctl_rd   = 1'b1;
      ioctl_addr = a;
      tick;
      ioctl_rd = 1'b0;
      if (prog) begin
         checkOutput($sformatf("fetch%0d.wait", a),    32'(ioctl_wait), 32'h1);
         checkOutput($sformatf("fetch%0d.ramRd", a),   32'(ram_rd),     32'h1);
         checkOutput($sformatf("fetch%0d.ramAddr", a), 32'(ram_addr),   32'(expAddr));
         n = 0;
         while (ioctl_wait && n < 8) begin
            tick;
            n++;
         end
         checkOutput($sformatf("fetch%0d.waitCycles", a), 32'(n), 32'd2);
      end else begin
         checkOutput($sformatf("rd%0d.wait", a),  32'(ioctl_wait), 32'h0);
         checkOutput($sformatf("rd%0d.ramRd", a), 32'(ram_rd),     32'h0);
      end
      checkOutput($sformatf("rd%0d.din", a), 32'(ioctl_din), 32'(expQ.pop_front()));
   endtask

   initial begin
      logic [191:0] hdrVal;

      reset        = 1'b1;
      ioctl_upload = 1'b0;
      ioctl_rd     = 1'b0;
      ioctl_addr   = 16'h0000;

      for (int i = 0; i < 65536; i++) mem[i] = 8'(i) ^ 8'h3C;
      mem[16'h78F9] = 8'hE9;
      mem[16'h78FA] = 8'h7B;
      mem[16'h7AE9] = 8'hA5;

      hdrVal = 192'h565A4630_4C415345_52333130_000000000000000000_F0_E9_7A;
      for (int i = 0; i < 24; i++) begin
         vecs[i] = '{16'(i), hdrVal[8*(23-i) +: 8], 1'b0};
      end
      vecs[24] = '{16'd24,  8'hA5,         1'b1};
      vecs[25] = '{16'd279, mem[16'h7BE8], 1'b1};
      vecs[26] = '{16'd280, 8'h00,         1'b0};

      tick;
      tick;
      checkIdle("reset");
      reset = 1'b0;
      tick;

      // Normal session: header, first/last program bytes, one past the end
      raiseUpload(16'h0118);
      for (int i = 0; i < 27; i++) begin
         applyStimulus(vecs[i].addr, vecs[i].din, vecs[i].prog);
      end

      // Empty program (end == start)
      ioctl_upload = 1'b0;
      tick;
      checkOutput("drop.sizeValid", 32'(size_valid), 32'h0);
      mem[16'h78FA] = 8'h7A;
      raiseUpload(16'h0018);
      applyStimulus(16'd24, 8'h00, 1'b0);

      // End pointer below the program area
      ioctl_upload = 1'b0;
      tick;
      mem[16'h78F9] = 8'h00;
      mem[16'h78FA] = 8'h70;
      raiseUpload(16'h0018);
      applyStimulus(16'd24, 8'h00, 1'b0);

      // One-byte program
      ioctl_upload = 1'b0;
      tick;
      mem[16'h78F9] = 8'hEA;
      mem[16'h78FA] = 8'h7A;
      raiseUpload(16'h0019);
      applyStimulus(16'd24, 8'hA5, 1'b1);
      applyStimulus(16'd25, 8'h00, 1'b0);

      // Abort during FETCH
      ioctl_upload = 1'b0;
      tick;
      mem[16'h78F9] = 8'hE9;
      mem[16'h78FA] = 8'h7B;
      raiseUpload(16'h0118);
      applyStimulus(16'd0, 8'h56, 1'b0);
      ioctl_rd   = 1'b1;
      ioctl_addr = 16'd24;
      tick;
      ioctl_rd = 1'b0;
      checkOutput("abort.fetchRamRd", 32'(ram_rd), 32'h1);
      ioctl_upload = 1'b0;
      tick;
      checkIdle("abort");
      tick;
      checkOutput("abort.ramRdLater", 32'(ram_rd), 32'h0);

      // Re-raise after abort: full sequence again
      raiseUpload(16'h0118);
      applyStimulus(16'd24, 8'hA5, 1'b1);

      // Reset during PTR_HI
      ioctl_upload = 1'b0;
      tick;
      ioctl_upload = 1'b1;
      tick;
      tick;
      checkOutput("preReset.ramAddr", 32'(ram_addr), 32'h78FA);
      reset        = 1'b1;
      ioctl_upload = 1'b0;
      tick;
      checkIdle("midReset");
      reset = 1'b0;
      tick;
      raiseUpload(16'h0118);
      applyStimulus(16'd22, 8'hE9, 1'b0);

      checkOutput("scoreboardEmpty", 32'(expQ.size()), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
